// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Purpose
//   Brings the system PLL up from the 27 MHz board clock and gates the core
//   reset on it. Each attempt pulses the PLL RESET pin, waits (with timeout)
//   for LOCK, and requires LOCK to stay high for a settle window before it
//   releases sys_reset_n. If lock is lost while running, or the wait times
//   out, the attempt counts as a failure and the whole sequence runs again.
//   After MAX_RETRIES failed attempts the block parks in a sticky fail state
//   that only reset_n clears. This block never runs on the PLL output clock.
//   Each consumer domain re-synchronises sys_reset_n itself.
//
// Parameters
//   RST_CYCLES      clk cycles pll_reset is held high per attempt (>= 1)
//   LOCK_TIMEOUT    clk cycles allowed waiting for lock before a retry
//   SETTLE_CYCLES   consecutive locked cycles required before release
//   MAX_RETRIES     failed attempts tolerated before the fail state (1..15)
//   DEGLITCH_CYCLES consecutive lock-low cycles in RUN that count as a real
//                   loss of lock (only with PLL_LOCK_DEGLITCH_EN)
//
// Ports
//   clk          in   1  27 MHz board clock
//   reset_n      in   1  synchronous, active-low reset
//   pll_lock     in   1  raw PLL LOCK, asynchronous to clk
//   pll_reset    out  1  PLL RESET pin, active high
//   sys_reset_n  out  1  core reset, low until the PLL is declared good
//   pll_ok       out  1  high only in RUN
//   fail         out  1  sticky, high in the fail state
//   retry_cnt    out  4  failed attempts since reset_n, saturates at MAX_RETRIES
//   state        out  3  current FSM state (debug)
//
// Configuration macro
//   PLL_LOCK_DEGLITCH_EN  when defined, lock_s must stay low for
//                         DEGLITCH_CYCLES consecutive cycles in RUN before the
//                         loss counts; shorter lows are ignored. When not
//                         defined, a single low cycle in RUN is a failure.
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int RST_CYCLES      = 32,
    parameter int LOCK_TIMEOUT    = 270000,
    parameter int SETTLE_CYCLES   = 2700,
    parameter int MAX_RETRIES     = 7,
    parameter int DEGLITCH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset_n,
    output logic       pll_ok,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    // -------------------------------------------------------------------------
    // Run-state lock-loss threshold. Without deglitching a single low cycle is
    // enough, so the same counter compare below covers both builds.
    // -------------------------------------------------------------------------
`ifdef PLL_LOCK_DEGLITCH_EN
    localparam int LOW_LIMIT = DEGLITCH_CYCLES;
`else
    // DEGLITCH_CYCLES has no effect in this build; it is multiplied out so the
    // parameter remains referenced.
    localparam int LOW_LIMIT = 1 + 0 * DEGLITCH_CYCLES;
`endif

    // -------------------------------------------------------------------------
    // Shared phase counter sizing: it must hold the largest terminal count of
    // any state that uses it.
    // -------------------------------------------------------------------------
    localparam int MAX_AB  = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int MAX_ABC = (MAX_AB > RST_CYCLES) ? MAX_AB : RST_CYCLES;
    localparam int MAX_ALL = (MAX_ABC > LOW_LIMIT) ? MAX_ABC : LOW_LIMIT;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    // Terminal counts: the counter starts at 0 on state entry, so "N cycles
    // spent in the state" is reached when the counter reads N-1.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_LAST     = CNT_W'(LOW_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    // -------------------------------------------------------------------------
    // State encoding is visible on the debug port, so values are fixed.
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;

    // Lock synchroniser; lock_s is the only form of pll_lock the FSM sees.
    logic             sync1_q, sync2_q;
    logic             lock_s;

    // Registered outputs, computed from the next state so that each output
    // always agrees with the state register it is shipped alongside.
    logic             pll_reset_q,   pll_reset_d;
    logic             sys_reset_n_q, sys_reset_n_d;
    logic             pll_ok_q,      pll_ok_d;
    logic             fail_q,        fail_d;

    logic             attempt_failed;

    assign lock_s = sync2_q;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous LOCK input.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_lock;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, counter and retry logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        retry_d        = retry_q;
        attempt_failed = 1'b0;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_WAIT_LOCK: begin
                // Lock is tested first so that lock arriving on the very
                // cycle the timeout expires still wins.
                if (lock_s) begin
                    state_d = ST_SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    attempt_failed = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_SETTLE: begin
                // A drop here is not a failure: go back and wait again with
                // a fresh timeout.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_RUN: begin
                // In RUN the counter tracks consecutive low cycles; any high
                // cycle restarts the run.
                if (lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOW_LAST) begin
                    attempt_failed = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_FAIL: begin
                // Parked until reset_n.
                state_d = ST_FAIL;
            end

            default: begin
                // Unused encodings recover through a fresh reset pulse.
                state_d = ST_PLL_RST;
            end
        endcase

        // A failed attempt either retries or, once the budget is spent,
        // parks in the fail state with retry_cnt left at its maximum.
        if (attempt_failed) begin
            if (retry_q >= RETRY_MAX) begin
                state_d = ST_FAIL;
            end else begin
                retry_d = retry_q + 4'd1;
                state_d = ST_PLL_RST;
            end
        end

        // Every state change starts the shared counter from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state.
    // -------------------------------------------------------------------------
    always_comb begin
        pll_reset_d   = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
        sys_reset_n_d = (state_d == ST_RUN);
        pll_ok_d      = (state_d == ST_RUN);
        fail_d        = (state_d == ST_FAIL);
    end

    // -------------------------------------------------------------------------
    // State, counter, retry and output registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_PLL_RST;
            cnt_q         <= '0;
            retry_q       <= 4'd0;
            pll_reset_q   <= 1'b1;
            sys_reset_n_q <= 1'b0;
            pll_ok_q      <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_reset_q   <= pll_reset_d;
            sys_reset_n_q <= sys_reset_n_d;
            pll_ok_q      <= pll_ok_d;
            fail_q        <= fail_d;
        end
    end

    assign pll_reset   = pll_reset_q;
    assign sys_reset_n = sys_reset_n_q;
    assign pll_ok      = pll_ok_q;
    assign fail        = fail_q;
    assign retry_cnt   = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Drives pll_lock / reset_n with directed scenarios followed by random lock
// patterns, and compares every output after every clock edge against a
// behavioural model. The model describes the sequencer as phases with a
// "cycles spent in this phase" age, a failure tally and a queue standing in
// for the two-cycle lock latency. Built with PLL_LOCK_DEGLITCH_EN defined,
// the RUN-state loss threshold becomes DEGLITCH_CYCLES.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam int RST_CYC = 4;
    localparam int TIMEOUT = 100;
    localparam int SETTLE  = 10;
    localparam int MAXR    = 2;
    localparam int DGL     = 4;

`ifdef PLL_LOCK_DEGLITCH_EN
    localparam int LOW_NEEDED = DGL;
`else
    localparam int LOW_NEEDED = 1;
`endif

    localparam int PH_RST    = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAIL   = 4;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic       sys_reset_n;
    logic       pll_ok;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int phase        = PH_RST;
    int phase_cycles = 0;
    int failures     = 0;
    int low_streak   = 0;
    bit lock_pipe[$];

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES     (RST_CYC),
        .LOCK_TIMEOUT   (TIMEOUT),
        .SETTLE_CYCLES  (SETTLE),
        .MAX_RETRIES    (MAXR),
        .DEGLITCH_CYCLES(DGL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .sys_reset_n(sys_reset_n),
        .pll_ok     (pll_ok),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic enter(input int ph);
        phase        = ph;
        phase_cycles = 0;
        low_streak   = 0;
    endtask

    task automatic lose_attempt();
        if (failures == MAXR) begin
            enter(PH_FAIL);
        end else begin
            failures++;
            enter(PH_RST);
        end
    endtask

    // One clock edge with the given inputs present at the edge.
    task automatic model_edge(input bit lk, input bit rn);
        bit seen;
        if (!rn) begin
            enter(PH_RST);
            failures = 0;
            lock_pipe.delete();
            lock_pipe.push_back(1'b0);
            lock_pipe.push_back(1'b0);
        end else begin
            // The FSM acts on the lock value sampled two edges earlier.
            seen = lock_pipe.pop_front();
            lock_pipe.push_back(lk);
            case (phase)
                PH_RST: begin
                    if (phase_cycles + 1 >= RST_CYC) enter(PH_WAIT);
                    else phase_cycles++;
                end
                PH_WAIT: begin
                    if (seen) enter(PH_SETTLE);
                    else if (phase_cycles + 1 >= TIMEOUT) lose_attempt();
                    else phase_cycles++;
                end
                PH_SETTLE: begin
                    if (!seen) enter(PH_WAIT);
                    else if (phase_cycles + 1 >= SETTLE) enter(PH_RUN);
                    else phase_cycles++;
                end
                PH_RUN: begin
                    if (seen) begin
                        low_streak = 0;
                    end else begin
                        low_streak++;
                        if (low_streak >= LOW_NEEDED) lose_attempt();
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Apply inputs, take one edge, then compare every output to the model.
    task automatic step(input bit lk, input bit rn);
        pll_lock = lk;
        reset_n  = rn;
        @(posedge clk);
        #1;
        model_edge(lk, rn);
        check("state",       32'(state),       32'(phase));
        check("pll_reset",   32'(pll_reset),   32'(phase == PH_RST || phase == PH_FAIL));
        check("sys_reset_n", 32'(sys_reset_n), 32'(phase == PH_RUN));
        check("pll_ok",      32'(pll_ok),      32'(phase == PH_RUN));
        check("fail",        32'(fail),        32'(phase == PH_FAIL));
        check("retry_cnt",   32'(retry_cnt),   32'(failures));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_high;
        int rel_at;
        bit saw_wait;
        lock_pipe.push_back(1'b0);
        lock_pipe.push_back(1'b0);

        // 1: reset, lock tied high, clean bring-up
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        check("t1_reset_state", 32'(state), 32'd0);
        check("t1_reset_pllrst", 32'(pll_reset), 32'd1);
        n_high = pll_reset ? 1 : 0;
        for (int i = 0; i < RST_CYC + 2 + SETTLE + 2; i++) begin
            step(1'b1, 1'b1);
            if (pll_reset === 1'b1) n_high++;
        end
        check("t1_rst_len", 32'(n_high), 32'(RST_CYC));
        check("t1_released", 32'(sys_reset_n), 32'd1);
        check("t1_ok", 32'(pll_ok), 32'd1);
        check("t1_retry", 32'(retry_cnt), 32'd0);
        $display("txn bring-up: sys_reset_n=%0b retry=%0d", sys_reset_n, retry_cnt);

        // 2: lock never comes -> retries exhausted, sticky fail
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 1000 && phase != PH_FAIL; i++) step(1'b0, 1'b1);
        check("t2_fail", 32'(fail), 32'd1);
        check("t2_state", 32'(state), 32'd4);
        check("t2_retry", 32'(retry_cnt), 32'(MAXR));
        check("t2_pllrst", 32'(pll_reset), 32'd1);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b1);
        check("t2_sticky", 32'(state), 32'd4);
        $display("txn no-lock: state=%0d fail=%0b retry=%0d", state, fail, retry_cnt);

        // 6b: reset from the fail state
        step(1'b1, 1'b0);
        check("t6_fail_state", 32'(state), 32'd0);
        check("t6_fail_pllrst", 32'(pll_reset), 32'd1);
        check("t6_fail_flag", 32'(fail), 32'd0);
        check("t6_fail_retry", 32'(retry_cnt), 32'd0);
        $display("txn reset-in-fail: state=%0d retry=%0d", state, retry_cnt);

        // 3: one-cycle lock glitch during SETTLE
        for (int i = 0; i < 200 && !(phase == PH_SETTLE && phase_cycles == 5); i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        saw_wait = 1'b0;
        rel_at   = -1;
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, 1'b1);
            if (state === 3'd1) saw_wait = 1'b1;
            if (rel_at < 0 && sys_reset_n === 1'b1) rel_at = k;
        end
        check("t3_rewait", 32'(saw_wait), 32'd1);
        // Lock back at step 1, visible to the FSM two edges later (step 3,
        // WAIT->SETTLE), then SETTLE locked cycles before RUN.
        check("t3_release_at", 32'(rel_at), 32'(3 + SETTLE));
        check("t3_retry", 32'(retry_cnt), 32'd0);
        $display("txn settle-glitch: release after %0d steps retry=%0d", rel_at, retry_cnt);

        // 4: one-cycle lock loss in RUN
        step(1'b0, 1'b1);
        n_high = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1);
            if (pll_reset === 1'b1) n_high++;
        end
`ifdef PLL_LOCK_DEGLITCH_EN
        check("t4_pulse", 32'(n_high), 32'd0);
        check("t4_retry", 32'(retry_cnt), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("t4_long_retry", 32'(retry_cnt), 32'd1);
`else
        check("t4_pulse", 32'(n_high), 32'(RST_CYC));
        check("t4_retry", 32'(retry_cnt), 32'd1);
`endif
        for (int i = 0; i < 100 && phase != PH_RUN; i++) step(1'b1, 1'b1);
        check("t4_rerun", 32'(pll_ok), 32'd1);
        $display("txn run-glitch: retry=%0d pll_reset pulse=%0d", retry_cnt, n_high);

        // 5: lock arrives on the exact timeout cycle
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 300 && !(phase == PH_WAIT && phase_cycles == TIMEOUT - 3); i++) step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("t5_settle", 32'(state), 32'd2);
        check("t5_retry", 32'(retry_cnt), 32'd0);
        $display("txn timeout-race: state=%0d retry=%0d", state, retry_cnt);

        // 6a: reset during SETTLE
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("t6_settle_state", 32'(state), 32'd0);
        check("t6_settle_pllrst", 32'(pll_reset), 32'd1);
        check("t6_settle_fail", 32'(fail), 32'd0);
        check("t6_settle_retry", 32'(retry_cnt), 32'd0);
        $display("txn reset-in-settle: state=%0d", state);

        // 7: random lock patterns with occasional resets
        for (int seg = 0; seg < 150; seg++) begin
            int  len;
            bit  lk;
            bit  rn;
            rn  = ($urandom_range(0, 24) != 0);
            lk  = ($urandom_range(0, 9) < 7);
            if (!rn)                              len = $urandom_range(1, 3);
            else if ($urandom_range(0, 7) == 0)   len = $urandom_range(60, 130);
            else                                  len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) step(lk, rn);
            $display("txn random %0d: lock=%0b rst_n=%0b len=%0d -> state=%0d retry=%0d",
                     seg, lk, rn, len, state, retry_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
